// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher
//   Stretches single-cycle event strobes into human-visible LED windows and
//   dims the LED drive with a shared PWM stage.
//
//   Each channel holds "active" high for hold_count_max cycles after its most
//   recent pulse; a new pulse during the window restarts it with no gap. The
//   PWM brightness is captured only at the end of a PWM period so the duty
//   cycle never changes partway through a period.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   pulse_in    [width]    per-channel event strobes, synchronous to clk
//   brightness  [pwm_bits] requested duty, on for brightness/2^pwm_bits cycles
//   active      [width]    stretched window per channel, registered, undimmed
//   led_out     [width]    active gated by the PWM, drives the LEDs
module led_pulse_stretcher #(
  parameter int width          = 4,
  parameter int hold_count_max = 12500000,
  parameter int pwm_bits       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [width-1:0]    pulse_in,
  input  logic [pwm_bits-1:0] brightness,
  output logic [width-1:0]    active,
  output logic [width-1:0]    led_out
);

  localparam int cnt_bits = $clog2(hold_count_max + 1);
  // The counter counts down to zero, so a window of hold_count_max cycles
  // starts from hold_count_max-1 (the load cycle itself is the first one).
  localparam logic [cnt_bits-1:0] reload = cnt_bits'(hold_count_max - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t              state [width];
  logic [cnt_bits-1:0] cnt   [width];

  // Per-channel window FSM. active is registered alongside the state so it
  // is high exactly while the channel is in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counters are a handful of flops, not a RAM, so every entry
      // is cleared on reset; a reset mid-window must not resume the old one.
      for (int i = 0; i < width; i++) begin
        state[i]  <= IDLE;
        cnt[i]    <= '0;
        active[i] <= 1'b0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every channel's next state a
      // function of the pre-edge values only, independent of statement order.
      for (int i = 0; i < width; i++) begin
        case (state[i])
          IDLE: begin
            if (pulse_in[i]) begin
              state[i]  <= HOLD;
              cnt[i]    <= reload;
              active[i] <= 1'b1;
            end
          end
          HOLD: begin
            if (pulse_in[i]) begin
              cnt[i] <= reload;          // retrigger: extend, no gap
            end else if (cnt[i] != '0) begin
              cnt[i] <= cnt[i] - cnt_bits'(1);
            end else begin
              state[i]  <= IDLE;
              active[i] <= 1'b0;
            end
          end
          default: begin
            state[i]  <= IDLE;
            active[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Shared PWM. bright_q is loaded on the last count of a period so the new
  // duty applies from the next pwm_cnt = 0 onward.
  logic [pwm_bits-1:0] pwm_cnt;
  logic [pwm_bits-1:0] bright_q;
  logic                pwm_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      bright_q <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + pwm_bits'(1);
      if (pwm_cnt == '1) begin
        bright_q <= brightness;
      end
    end
  end

  // Only registers feed the output gate, so there is no combinational path
  // from any input to led_out.
  assign pwm_on  = (pwm_cnt < bright_q);
  assign led_out = active & {width{pwm_on}};

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb_led_pulse_stretcher
//   Drives two instances (hold_count_max = 8 and = 1, pwm_bits = 2) from the
//   same stimulus and compares them every cycle against a timeline model:
//   a channel is active in cycle c when its most recent pulse happened in
//   cycle c-H .. c-1; the PWM phase is c mod 4 counted from reset release,
//   and the duty for a period is the brightness seen in the last cycle of
//   the previous period.
module tb_led_pulse_stretcher;

  localparam int w  = 4;
  localparam int pb = 2;
  localparam int hl = 8;
  localparam int period = 1 << pb;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [w-1:0]  pulse_in;
  logic [pb-1:0] brightness;
  logic [w-1:0]  active, led_out;
  logic [w-1:0]  active1, led1;

  led_pulse_stretcher #(.width(w), .hold_count_max(hl), .pwm_bits(pb)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .brightness(brightness),
    .active(active), .led_out(led_out)
  );

  led_pulse_stretcher #(.width(w), .hold_count_max(1), .pwm_bits(pb)) dut1 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .brightness(brightness),
    .active(active1), .led_out(led1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Timeline model state
  int c;             // cycle index since reset release
  int last [w];      // cycle of most recent pulse per channel
  bit seen [w];      // channel has had a pulse since release
  int bq;            // duty in force during cycle c

  task automatic check(input string tag, input logic [w-1:0] obs,
                       input logic [w-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b cycle=%0d", tag, obs, exp, c);
    end
  endtask

  function automatic logic [w-1:0] exp_active(input int h);
    logic [w-1:0] e;
    for (int i = 0; i < w; i++)
      e[i] = seen[i] && (c - last[i] >= 1) && (c - last[i] <= h);
    return e;
  endfunction

  function automatic logic [w-1:0] exp_led(input int h);
    return exp_active(h) & {w{(c % period) < bq}};
  endfunction

  // One clock cycle: called at a negedge, drives the inputs for cycle c,
  // checks outputs, then advances the model across the rising edge.
  task automatic cycle(input logic [w-1:0] p, input logic [pb-1:0] b);
    pulse_in   = p;
    brightness = b;
    #1;
    check("active_h8", active,  exp_active(hl));
    check("led_h8",    led_out, exp_led(hl));
    check("active_h1", active1, exp_active(1));
    check("led_h1",    led1,    exp_led(1));
    @(posedge clk);
    for (int i = 0; i < w; i++)
      if (p[i]) begin
        seen[i] = 1'b1;
        last[i] = c;
      end
    if (c % period == period - 1) bq = int'(b);
    c++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [pb-1:0] b);
    repeat (n) cycle('0, b);
  endtask

  // Assert reset dly time units after the current negedge, hold it n cycles
  // with all pulses high, and release at a negedge with a fresh model.
  task automatic reset_seq(input int dly, input int n);
    if (dly > 0) #(dly);
    rst_n      = 1'b0;
    pulse_in   = '1;
    brightness = '1;
    #1;
    check("rst_active", active, '0);
    check("rst_led",    led_out, '0);
    check("rst_active_h1", active1, '0);
    repeat (n) begin
      @(negedge clk);
      #1;
      check("rst_active", active, '0);
      check("rst_led",    led_out, '0);
      check("rst_led_h1", led1, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < w; i++) begin
      seen[i] = 1'b0;
      last[i] = 0;
    end
    bq = 0;
    c  = 0;
  endtask

  initial begin
    logic [w-1:0] p;
    rst_n      = 1'b0;
    pulse_in   = '0;
    brightness = '0;
    @(negedge clk);

    // Reset with all inputs asserted, then an isolated pulse on ch0
    reset_seq(0, 3);
    idle(2, 3);
    cycle(4'b0001, 3);
    idle(10, 3);

    // Retrigger at N and N+5, then ch1 held high for 20 cycles
    cycle(4'b0010, 3);
    idle(4, 3);
    cycle(4'b0010, 3);
    idle(12, 3);
    repeat (20) cycle(4'b0010, 3);
    idle(10, 3);

    // Simultaneous and independent channels
    cycle(4'b1010, 3);
    idle(2, 3);
    cycle(4'b0001, 3);
    idle(12, 3);

    // PWM duty with ch2 held active
    repeat (12) cycle(4'b0100, 2);
    repeat (12) cycle(4'b0100, 0);
    repeat (12) cycle(4'b0100, 3);

    // Brightness latch: change 1 -> 3 at pwm_cnt = 1
    while (c % period != 0) cycle(4'b0100, 1);
    repeat (8) cycle(4'b0100, 1);
    cycle(4'b0100, 1);
    repeat (9) cycle(4'b0100, 3);
    idle(10, 3);

    // Reset four cycles into a window; old window must not resume
    cycle(4'b0001, 3);
    idle(3, 3);
    reset_seq(2, 2);
    idle(12, 3);
    cycle(4'b0100, 3);
    idle(3, 3);

    // Randomized traffic with one reset in the middle
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < w; i++) p[i] = ($urandom_range(7) == 0);
      cycle(p, pb'($urandom_range(period - 1)));
      if (k == 300) reset_seq(int'($urandom_range(3)), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pulse_stretcher.md
Name: led_pulse_stretcher

Overview:
- Output-side counterpart of the button input chain: turns single-cycle event pulses into human-visible LED drive.
- Typical sources are edge-detector strobes and FSM events.
- Each channel stretches a 1-cycle pulse into a fixed-length "active" window and re-triggers on new pulses.
- A shared PWM stage dims the LED drive using a runtime brightness value that is only updated at PWM period boundaries, so duty never glitches.

Parameters:
- width, 4: number of independent channels.
- hold_count_max, 12500000: active-window length in clk cycles; must be ≥1. 100 ms at 125 MHz.
- pwm_bits, 4: PWM counter width. The PWM period is 2^pwm_bits cycles.

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pulse_in  input  width  per-channel event strobes, synchronous to clk, any duty.
- brightness  input  pwm_bits  requested duty: LED on for brightness out of 2^pwm_bits cycles. 0 means off.
- active  output  width  per-channel stretched window, undimmed, registered.
- led_out  output  width  active AND PWM gate, drives LEDs.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-release assumed upstream):
  - active = 0, led_out = 0, all hold counters = 0.
  - pwm_cnt = 0, bright_q = 0.
- Per-channel FSM, two states, IDLE and HOLD. The counter is $clog2(hold_count_max+1) bits wide.
  - IDLE, pulse_in[i]=1 → HOLD, cnt loaded with hold_count_max-1. active[i] rises on the next edge (1-cycle latency).
  - HOLD, pulse_in[i]=1 → cnt reloaded to hold_count_max-1 (retrigger extends the window; no gap).
  - HOLD, pulse_in[i]=0, cnt≠0 → cnt decrements.
  - HOLD, pulse_in[i]=0, cnt=0 → IDLE.
  - active[i]=1 exactly while in HOLD. An isolated pulse gives exactly hold_count_max cycles high.
  - hold_count_max=1 gives active as a 1-cycle delayed copy of pulse_in.
  - pulse_in held high gives active continuously high. active falls hold_count_max cycles after the last high pulse cycle.
  - Channels are fully independent. Simultaneous pulses on several channels are all honoured in the same cycle.
- PWM:
  - pwm_cnt free-runs 0 … 2^pwm_bits-1 and wraps to 0.
  - bright_q <= brightness only on the edge where pwm_cnt = 2^pwm_bits-1, so a new value takes effect at the next period start (pwm_cnt=0).
  - Mid-period brightness changes are ignored until the wrap.
  - pwm_on = (pwm_cnt < bright_q). Unsigned compare, pwm_bits wide.
  - bright_q=0 gives always off. Maximum duty is (2^pwm_bits-1)/2^pwm_bits; full-on is not required.
- led_out[i] = active[i] & pwm_on:
  - Combinational AND of registers only; no input-to-output combinational path.
  - For the first cycle after reset release, bright_q=0, so led_out=0 until the first wrap loads brightness.
- Reset asserted mid-window: outputs clear immediately (asynchronously). After release, the channel is IDLE and the old window is not resumed.
- The PWM counter runs regardless of channel activity. A window may start or end mid-PWM-period with no realignment.

Test Plan (width=4, hold_count_max=8, pwm_bits=2 unless noted):
1. Reset: hold rst_n=0 with pulse_in=4'hF and brightness=3 → active=0, led_out=0 throughout. Release, then pulse ch0 once at cycle N → active[0] high for cycles N+1 … N+8 exactly, low at N+9.
2. Retrigger: pulse ch1 at cycle N and again at N+5 → active[1] continuously high N+1 … N+13, low at N+14. Pulse ch1 held high for 20 cycles → active high for 27 consecutive cycles.
3. Simultaneous and independent: pulse_in=4'b1010 at cycle N, then 4'b0001 at N+3 → ch1/ch3 high N+1 … N+8, ch0 high N+4 … N+11, ch2 never high.
4. PWM duty: brightness=2 with ch2 held active → after the first wrap, led_out[2] follows pattern 1,1,0,0 per 4-cycle period, aligned to pwm_cnt=0. brightness=0 → led_out=0. brightness=3 → pattern 1,1,1,0.
5. Brightness latch: change brightness 1→3 when pwm_cnt=1 → the remaining cycles of that period still use duty 1 (led_out 0,0 for pwm_cnt 2,3). The next period shows 1,1,1,0.
6. Mid-window reset: assert rst_n=0 four cycles into a window → active/led_out drop within the same cycle. After release, no output until a new pulse arrives. hold_count_max=1 variant: a single pulse gives a single-cycle active.
